seq11011_gen: RTL and testbench

Moore-style serial sequence generator: the transmit-side counterpart of the overlapping 11011 sequence detector. On a start request it emits a fixed bit pattern MSB-first, one bit per accepted transfer, repeated a programmable number of times either back-to-back (full copies) or overlapped (shared prefix/suffix bits omitted). Its `dout` is used to drive the detector's serial input in system tests, and as a pattern source elsewhere in the design.

---
 rtl/seq11011_gen.sv | 115 +++++++++++
 tb/tb_seq11011_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq11011_gen.sv
// Serial pattern generator: emits PATTERN MSB-first under ready/valid handshake,
// repeated rep_cnt times either as full copies or with the self-overlap prefix skipped.
module seq11011_gen #(
  parameter int                   PATTERN_W = 5,
  parameter logic [PATTERN_W-1:0] PATTERN   = 5'b11011,
  parameter int                   OVL_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] rep_cnt,
  input  logic       overlap,
  input  logic       ready,
  output logic       dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // SHIFT | presenting shreg MSB, advancing on each accepted bit
  // DONE  | one-cycle completion pulse, busy still high
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int                   IW       = $clog2(PATTERN_W);
  localparam logic [IW-1:0]        IDX_TOP  = IW'(PATTERN_W - 1);
  localparam logic [IW-1:0]        IDX_OVL  = IW'(PATTERN_W - 1 - OVL_LEN);
  localparam logic [PATTERN_W-1:0] PAT_OVL  = PATTERN << OVL_LEN;

  state_t                 state, state_nxt;
  logic [PATTERN_W-1:0]   shreg, shreg_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [3:0]             rep, rep_nxt;
  logic                   ovl, ovl_nxt;
  logic                   dout_nxt, valid_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      rep        <= '0;
      ovl        <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      idx        <= idx_nxt;
      rep        <= rep_nxt;
      ovl        <= ovl_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    rep_nxt   = rep;
    ovl_nxt   = ovl;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          rep_nxt   = (rep_cnt == 4'd0) ? 4'd1 : rep_cnt;
          ovl_nxt   = overlap;
          shreg_nxt = PATTERN;
          idx_nxt   = IDX_TOP;
        end
      end
      SHIFT: begin
        if (ready) begin
          if (idx == '0) begin
            if (rep <= 4'd1) begin
              state_nxt = DONE;
            end else begin
              rep_nxt = rep - 4'd1;
              // overlapped copies skip the prefix already sent as the previous suffix
              if (ovl) begin
                shreg_nxt = PAT_OVL;
                idx_nxt   = IDX_OVL;
              end else begin
                shreg_nxt = PATTERN;
                idx_nxt   = IDX_TOP;
              end
            end
          end else begin
            shreg_nxt = {shreg[PATTERN_W-2:0], 1'b0};
            idx_nxt   = idx - IW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // outputs are decoded from the next state so they can be registered
    dout_nxt  = (state_nxt == SHIFT) & shreg_nxt[PATTERN_W-1];
    valid_nxt = (state_nxt == SHIFT);
    busy_nxt  = (state_nxt == SHIFT) || (state_nxt == DONE);
    done_nxt  = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_seq11011_gen.sv
// Directed bench for seq11011_gen: vector table for single runs and edge cases,
// plus hand-written runs for repeats, backpressure and reset mid-run.
module tb_seq11011_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rep_cnt = 4'd0;
  logic       overlap = 1'b0;
  logic       ready = 1'b0;
  logic       dout, dout_valid, busy, done;

  int checks = 0;
  int errors = 0;

  seq11011_gen dut (
    .clk(clk), .rst(rst), .start(start), .rep_cnt(rep_cnt), .overlap(overlap),
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // exp = {dout, dout_valid, busy, done} after the edge
  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] rep;
    logic       ov;
    logic       rdy;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({dout, dout_valid, busy, done});
  endfunction

  task automatic run_seq(input string name, input logic [3:0] rep, input logic ov,
                         input string exp, input int exp_det);
    int nacc = 0;
    int bad = 0;
    int det = 0;
    int cyc = 0;
    int busy_low = 0;
    logic [4:0] win = '0;
    rst = 1'b0; start = 1'b1; rep_cnt = rep; overlap = ov; ready = 1'b1;
    step();
    cyc = 1;
    // scramble run configuration to prove it was latched
    start = 1'b0; rep_cnt = 4'd9; overlap = ~ov;
    while (!done && cyc < 200) begin
      if (!busy) busy_low++;
      if (dout_valid && ready) begin
        if (nacc >= exp.len() || int'(dout) != ((exp[nacc] == 8'h31) ? 1 : 0)) bad++;
        nacc++;
        win = {win[3:0], dout};
        if (win == 5'b11011) det++;
      end
      step();
      cyc++;
    end
    check({name, "_done_seen"}, int'(done), 1);
    check({name, "_done_cycle"}, cyc, exp.len() + 1);
    check({name, "_nbits"}, nacc, exp.len());
    check({name, "_bit_errs"}, bad, 0);
    check({name, "_detections"}, det, exp_det);
    check({name, "_busy_low_in_run"}, busy_low, 0);
    step();
    check({name, "_idle_after"}, outs(), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b1, 1'b1, 4'd1,  1'b0, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 4'b1110};
    vecs[4]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b1110};
    vecs[5]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b0110};
    vecs[6]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b1110};
    vecs[7]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b1110};
    vecs[8]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b0011};
    vecs[9]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b1, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'b1110};
    vecs[11] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'b1110};
    vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'b0110};
    vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'b1110};
    vecs[14] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'b1110};
    vecs[15] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'b0011};
    vecs[16] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'b0000};
    vecs[17] = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'b1110};
    vecs[18] = '{1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'b1110};
    vecs[19] = '{1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'b0110};
    vecs[20] = '{1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'b1110};
    vecs[21] = '{1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'b1110};
    vecs[22] = '{1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 4'b0011};
    vecs[23] = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 4'b0000};
    vecs[24] = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b1, 4'b0000};

    for (int i = 0; i < 25; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; rep_cnt = vecs[i].rep;
      overlap = vecs[i].ov; ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_outs", i), outs(), int'(vecs[i].exp));
    end

    run_seq("rep3_full", 4'd3, 1'b0, "110111101111011", 3);
    run_seq("rep3_ovl", 4'd3, 1'b1, "11011011011", 3);

    // backpressure: ready per cycle after the start edge
    begin
      logic [7:0] rdy_pat = 8'b11101001;  // LSB first: 1,0,0,1,0,1,1,1
      logic [4:0] acc = '0;
      int nacc = 0;
      int unstable = 0;
      logic prev_d = 1'b0;
      logic prev_hold = 1'b0;
      start = 1'b1; rep_cnt = 4'd1; overlap = 1'b0; ready = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
        ready = rdy_pat[c];
        if (prev_hold && dout != prev_d) unstable++;
        if (dout_valid && ready) begin
          acc = {acc[3:0], dout};
          nacc++;
        end
        prev_hold = dout_valid && !ready;
        prev_d = dout;
        step();
      end
      check("bp_nacc", nacc, 5);
      check("bp_bits", int'(acc), int'(5'b11011));
      check("bp_dout_stable", unstable, 0);
      check("bp_done", outs(), int'(4'b0011));
      step();
      check("bp_idle", outs(), 0);
    end

    // reset after the third accepted bit, with start asserted alongside rst
    begin
      int done_seen = 0;
      start = 1'b1; rep_cnt = 4'd3; overlap = 1'b0; ready = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("rst_mid_pre", outs(), int'(4'b1110));
      rst = 1'b1; start = 1'b1;
      step();
      check("rst_mid_outs", outs(), 0);
      rst = 1'b0; start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (done || busy || dout_valid) done_seen++;
        step();
      end
      check("rst_mid_quiet", done_seen, 0);
    end

    run_seq("after_rst_ovl2", 4'd2, 1'b1, "11011011", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
